rr_grant_arbiter: RTL and testbench

//   8-way round-robin arbiter for one shared resource (bus/port) among 8 requesters.

---
 rtl/rr_grant_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// ============================================================================
// Module      : rr_grant_arbiter
// Description : 8-way round-robin arbiter with one-hot registered grant, hold
//               timeout and a one-cycle turnaround gap between owners.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_arbiter #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**IDX_W-1:0] req,
  output logic [2**IDX_W-1:0] gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid,
  output logic                timeout
);

  localparam int                N           = 2**IDX_W;
  localparam logic              c_tmo_en    = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]      c_one       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [N-1:0]      r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_nxt;
  logic              r_gnt_valid, w_gnt_valid_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic [IDX_W-1:0]  w_cand;

  // Walk from the farthest offset down so the candidate nearest ptr wins last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = r_ptr + IDX_W'(i);
      if (req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_found) begin
          w_state_nxt     = S_GRANT;
          w_gnt_idx_nxt   = w_winner;
          w_gnt_nxt       = c_one << w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = '0;
        end else begin
          w_state_nxt     = S_IDLE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        // A voluntary drop takes precedence over a coincident timeout.
        if (!req[r_gnt_idx] || (c_tmo_en && (r_hold_cnt == c_hold_last))) begin
          w_state_nxt     = S_GAP;
          w_ptr_nxt       = r_gnt_idx + IDX_W'(1);
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = req[r_gnt_idx];
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
// ============================================================================
// Module      : tb_rr_grant_arbiter
// Description : Directed self-checking bench for rr_grant_arbiter (MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_grant_arbiter #(.IDX_W(3), .MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    tick();
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: gnt=%h idx=%0d vld=%b tmo=%b want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rst = 1'b0;
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, gnt_valid} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset: gnt=%h vld=%b want 00/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_basic();
    req = 8'h05;
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL basic_first: gnt=%h idx=%0d vld=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h04;
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_gap: gnt=%h idx=%0d vld=%b tmo=%b want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL basic_second: gnt=%h idx=%0d vld=%b want 04/2/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [2:0] owner;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      owner = 3'(k % 8);
      tick();
      checks++;
      if ({gnt, gnt_idx, gnt_valid} !== {8'h01 << owner, owner, 1'b1}) begin
        errors++;
        $display("FAIL rotation_grant[%0d]: gnt=%h idx=%0d vld=%b want %h/%0d/1",
                 k, gnt, gnt_idx, gnt_valid, 8'h01 << owner, owner);
      end
      tick();
      req = 8'hFF & ~(8'h01 << owner);
      tick();
      checks++;
      if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rotation_gap[%0d]: gnt=%h vld=%b tmo=%b want 00/0/0", k, gnt, gnt_valid, timeout);
      end
      req = 8'hFF;
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h81;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({gnt, timeout} !== {8'h01, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold0[%0d]: gnt=%h tmo=%b want 01/0", c, gnt, timeout);
      end
    end
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_pulse0: gnt=%h vld=%b tmo=%b want 00/0/1", gnt, gnt_valid, timeout);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({gnt, gnt_idx, timeout} !== {8'h80, 3'd7, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold7[%0d]: gnt=%h idx=%0d tmo=%b want 80/7/0", c, gnt, gnt_idx, timeout);
      end
    end
    tick();
    checks++;
    if ({gnt, timeout} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL timeout_pulse7: gnt=%h tmo=%b want 00/1", gnt, timeout);
    end
    tick();
    checks++;
    if ({gnt, gnt_idx, timeout} !== {8'h01, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_wrap: gnt=%h idx=%0d tmo=%b want 01/0/0", gnt, gnt_idx, timeout);
    end
  endtask

  // Continues from test_timeout: owner 0 has just been granted (hold_cnt=0).
  task automatic test_drop_at_limit();
    tick();
    tick();
    tick();
    req = 8'h80;
    tick();
    checks++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drop_at_limit: gnt=%h vld=%b tmo=%b want 00/0/0", gnt, gnt_valid, timeout);
    end
    tick();
    checks++;
    if ({gnt, timeout} !== {8'h80, 1'b0}) begin
      errors++;
      $display("FAIL drop_next_owner: gnt=%h tmo=%b want 80/0", gnt, timeout);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 8'h10;
    tick();
    checks++;
    if ({gnt, gnt_idx} !== {8'h10, 3'd4}) begin
      errors++;
      $display("FAIL mid_setup: gnt=%h idx=%0d want 10/4", gnt, gnt_idx);
    end
    rst = 1'b1;
    req = 8'h30;
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: gnt=%h idx=%0d vld=%b tmo=%b want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h10, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL mid_regrant: gnt=%h idx=%0d vld=%b want 10/4/1", gnt, gnt_idx, gnt_valid);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_drop_at_limit();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
